// File: rtl/game_flow_controller.sv
// game_flow_controller: PAC-MAN game sequencer. Owns game state, score,
// lives, remaining dots and the power-pellet timer. Detects player/ghost
// collisions on character-update ticks and emits round/maze control pulses.
module game_flow_controller #(
  parameter int TOTAL_DOTS  = 240,
  parameter int START_LIVES = 3,
  parameter int READY_TICKS = 10,
  parameter int DYING_TICKS = 8,
  parameter int POWER_TICKS = 40,
  parameter int HIT_DIST    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        dot_eaten,
  input  logic        big_dot_eaten,
  input  logic [9:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [39:0] ghost_x,
  input  logic [35:0] ghost_y,
  output logic [2:0]  game_state,
  output logic        move_enable,
  output logic        power_mode,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [3:0]  ghost_home,
  output logic        round_reset,
  output logic        maze_reload
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READY     = 3'd1;
  localparam logic [2:0] ST_PLAYING   = 3'd2;
  localparam logic [2:0] ST_DYING     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;
  localparam logic [2:0] ST_WIN       = 3'd5;

  localparam int PHASE_MAX = (READY_TICKS > DYING_TICKS) ? READY_TICKS : DYING_TICKS;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int POWER_W   = $clog2(POWER_TICKS + 1);
  localparam int DOTS_W    = $clog2(TOTAL_DOTS + 1);

  logic [2:0]         state_q, state_d;
  logic [15:0]        score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [DOTS_W-1:0]  dots_left_q, dots_left_d;
  logic [POWER_W-1:0] power_cnt_q, power_cnt_d;
  logic [1:0]         combo_q, combo_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0]         ghost_home_q, ghost_home_d;
  logic               round_reset_q, round_reset_d;
  logic               maze_reload_q, maze_reload_d;

  logic [3:0]         hit;
  logic               power_on;
  logic [3:0]         eaten;
  logic [15:0]        ghost_pts;
  logic [1:0]         combo_run;
  logic [15:0]        dot_pts;
  logic [16:0]        score_sum;
  logic [DOTS_W+1:0]  dots_ext;
  logic [DOTS_W+1:0]  dots_dec;

  assign power_on = (power_cnt_q != '0);

  // Per-ghost box test: unsigned abs-diff on both axes, strictly below HIT_DIST
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      logic [9:0] gx, gy, py10, dx, dy;
      assign gx      = ghost_x[gi*10 +: 10];
      assign gy      = {1'b0, ghost_y[gi*9 +: 9]};
      assign py10    = {1'b0, player_y};
      assign dx      = (player_x >= gx) ? (player_x - gx) : (gx - player_x);
      assign dy      = (py10 >= gy) ? (py10 - gy) : (gy - py10);
      assign hit[gi] = (dx < 10'(HIT_DIST)) && (dy < 10'(HIT_DIST));
    end
  endgenerate

  // Ghost-eating bonus: walk ghosts in index order, each worth 200<<combo
  always_comb begin
    eaten     = '0;
    ghost_pts = '0;
    combo_run = combo_q;
    if (tick && power_on) begin
      for (int k = 0; k < 4; k++) begin
        if (hit[k]) begin
          eaten[k]  = 1'b1;
          ghost_pts = ghost_pts + (16'd200 << combo_run);
          if (combo_run != 2'd3) begin
            combo_run = combo_run + 2'd1;
          end
        end
      end
    end
  end

  assign dot_pts   = (dot_eaten ? 16'd10 : 16'd0) + (big_dot_eaten ? 16'd50 : 16'd0);
  assign score_sum = {1'b0, score_q} + {1'b0, dot_pts} + {1'b0, ghost_pts};
  assign dots_ext  = {2'b00, dots_left_q};
  assign dots_dec  = (DOTS_W+2)'(dot_eaten) + (DOTS_W+2)'(big_dot_eaten);

  // Next-state logic for the sequencer and all game counters
  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lives_d       = lives_q;
    dots_left_d   = dots_left_q;
    power_cnt_d   = power_cnt_q;
    combo_d       = combo_q;
    phase_d       = phase_q;
    ghost_home_d  = '0;
    round_reset_d = 1'b0;
    maze_reload_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER, ST_WIN: begin
        if (start) begin
          state_d       = ST_READY;
          score_d       = '0;
          lives_d       = 2'(START_LIVES);
          dots_left_d   = DOTS_W'(TOTAL_DOTS);
          power_cnt_d   = '0;
          combo_d       = '0;
          phase_d       = '0;
          maze_reload_d = 1'b1;
          round_reset_d = 1'b1;
        end
      end

      ST_READY: begin
        if (tick) begin
          if (phase_q == PHASE_W'(READY_TICKS - 1)) begin
            state_d = ST_PLAYING;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end

      ST_DYING: begin
        if (tick) begin
          if (phase_q == PHASE_W'(DYING_TICKS - 1)) begin
            phase_d = '0;
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d       = ST_READY;
              round_reset_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end

      ST_PLAYING: begin
        if (tick && !power_on && (hit != 4'b0000)) begin
          // Fatal collision takes priority over dots and the last-dot win
          state_d     = ST_DYING;
          power_cnt_d = '0;
          phase_d     = '0;
        end else begin
          score_d      = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          dots_left_d  = (dots_ext > dots_dec) ? DOTS_W'(dots_ext - dots_dec) : '0;
          ghost_home_d = eaten;
          combo_d      = combo_run;
          if (tick && power_on) begin
            power_cnt_d = power_cnt_q - 1'b1;
            if (power_cnt_q == POWER_W'(1)) begin
              combo_d = '0;
            end
          end
          // A fresh pellet restarts the timer and the combo chain
          if (big_dot_eaten) begin
            power_cnt_d = POWER_W'(POWER_TICKS);
            combo_d     = '0;
          end
          if (dots_left_d == '0) begin
            state_d = ST_WIN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any game in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      score_q       <= '0;
      lives_q       <= 2'(START_LIVES);
      dots_left_q   <= DOTS_W'(TOTAL_DOTS);
      power_cnt_q   <= '0;
      combo_q       <= '0;
      phase_q       <= '0;
      ghost_home_q  <= '0;
      round_reset_q <= 1'b0;
      maze_reload_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      dots_left_q   <= dots_left_d;
      power_cnt_q   <= power_cnt_d;
      combo_q       <= combo_d;
      phase_q       <= phase_d;
      ghost_home_q  <= ghost_home_d;
      round_reset_q <= round_reset_d;
      maze_reload_q <= maze_reload_d;
    end
  end

  assign game_state  = state_q;
  assign move_enable = (state_q == ST_PLAYING);
  assign power_mode  = power_on;
  assign score       = score_q;
  assign lives       = lives_q;
  assign ghost_home  = ghost_home_q;
  assign round_reset = round_reset_q;
  assign maze_reload = maze_reload_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: randomized stimulus, behavioural game model and a
// queue-based scoreboard compared by an independent monitor every cycle.
module tb_game_flow_controller;

  localparam int TOTAL_DOTS  = 30;
  localparam int START_LIVES = 3;
  localparam int READY_TICKS = 10;
  localparam int DYING_TICKS = 8;
  localparam int POWER_TICKS = 40;
  localparam int HIT_DIST    = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        dot_eaten = 1'b0;
  logic        big_dot_eaten = 1'b0;
  logic [9:0]  player_x = '0;
  logic [8:0]  player_y = '0;
  logic [39:0] ghost_x = '0;
  logic [35:0] ghost_y = '0;
  logic [2:0]  game_state;
  logic        move_enable;
  logic        power_mode;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [3:0]  ghost_home;
  logic        round_reset;
  logic        maze_reload;

  always #5 clk = ~clk;

  game_flow_controller #(
    .TOTAL_DOTS (TOTAL_DOTS),
    .START_LIVES(START_LIVES),
    .READY_TICKS(READY_TICKS),
    .DYING_TICKS(DYING_TICKS),
    .POWER_TICKS(POWER_TICKS),
    .HIT_DIST   (HIT_DIST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start        (start),
    .dot_eaten    (dot_eaten),
    .big_dot_eaten(big_dot_eaten),
    .player_x     (player_x),
    .player_y     (player_y),
    .ghost_x      (ghost_x),
    .ghost_y      (ghost_y),
    .game_state   (game_state),
    .move_enable  (move_enable),
    .power_mode   (power_mode),
    .score        (score),
    .lives        (lives),
    .ghost_home   (ghost_home),
    .round_reset  (round_reset),
    .maze_reload  (maze_reload)
  );

  typedef struct {
    int st; int sc; int lv; int me; int pm; int gh; int rr; int mr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  // Reference game model (plain integers)
  int m_state, m_score, m_lives, m_dots, m_power, m_combo, m_phase;
  // Stimulus as applied this cycle
  int s_px, s_py;
  int s_gx[4];
  int s_gy[4];
  // Stimulus knobs (percent, reset in per-mille)
  int p_tick = 30, p_dot = 15, p_big = 3, p_start = 30, p_near = 0, p_rst = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit st,
                            input bit de, input bit bd, output exp_t e);
    int gh, rr, mr, add, hits;
    gh = 0; rr = 0; mr = 0; add = 0; hits = 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_lives = START_LIVES; m_dots = TOTAL_DOTS;
      m_power = 0; m_combo = 0; m_phase = 0;
    end else begin
      case (m_state)
        0, 4, 5: if (st) begin
          m_state = 1; m_score = 0; m_lives = START_LIVES; m_dots = TOTAL_DOTS;
          m_power = 0; m_combo = 0; m_phase = 0; mr = 1; rr = 1;
        end
        1: if (tk) begin
          m_phase++;
          if (m_phase == READY_TICKS) begin m_state = 2; m_phase = 0; end
        end
        3: if (tk) begin
          m_phase++;
          if (m_phase == DYING_TICKS) begin
            m_phase = 0;
            m_lives--;
            if (m_lives == 0) m_state = 4;
            else begin m_state = 1; rr = 1; end
          end
        end
        2: begin
          for (int k = 0; k < 4; k++)
            if (iabs(s_px - s_gx[k]) < HIT_DIST && iabs(s_py - s_gy[k]) < HIT_DIST)
              hits |= (1 << k);
          if (tk && m_power == 0 && hits != 0) begin
            m_state = 3; m_power = 0; m_phase = 0;
          end else begin
            add = 10 * int'(de) + 50 * int'(bd);
            if (tk && m_power > 0) begin
              for (int k = 0; k < 4; k++) begin
                if ((hits & (1 << k)) != 0) begin
                  gh |= (1 << k);
                  add += 200 * (1 << m_combo);
                  if (m_combo < 3) m_combo++;
                end
              end
            end
            m_score += add;
            if (m_score > 65535) m_score = 65535;
            m_dots = m_dots - int'(de) - int'(bd);
            if (m_dots < 0) m_dots = 0;
            if (tk && m_power > 0) begin
              m_power--;
              if (m_power == 0) m_combo = 0;
            end
            if (bd) begin m_power = POWER_TICKS; m_combo = 0; end
            if (m_dots == 0) m_state = 5;
          end
        end
        default: ;
      endcase
    end
    e.st = m_state; e.sc = m_score; e.lv = m_lives;
    e.me = (m_state == 2) ? 1 : 0;
    e.pm = (m_power > 0) ? 1 : 0;
    e.gh = gh; e.rr = rr; e.mr = mr;
  endtask

  // One clock of stimulus: drive on the falling edge, model it, queue the result
  task automatic drive_cycle(input bit rst_in);
    exp_t e;
    @(negedge clk);
    s_px = int'($urandom_range(600, 20));
    s_py = int'($urandom_range(480, 20));
    for (int k = 0; k < 4; k++) begin
      if (int'($urandom_range(99, 0)) < p_near) begin
        s_gx[k] = s_px + int'($urandom_range(28, 0)) - 14;
        s_gy[k] = s_py + int'($urandom_range(28, 0)) - 14;
      end else begin
        s_gx[k] = s_px + 100 + int'($urandom_range(299, 0));
        s_gy[k] = (s_py + 100 + int'($urandom_range(199, 0))) % 512;
      end
      ghost_x[k*10 +: 10] = 10'(s_gx[k]);
      ghost_y[k*9 +: 9]   = 9'(s_gy[k]);
    end
    player_x      = 10'(s_px);
    player_y      = 9'(s_py);
    reset         = rst_in | (int'($urandom_range(999, 0)) < p_rst);
    tick          = int'($urandom_range(99, 0)) < p_tick;
    start         = int'($urandom_range(99, 0)) < p_start;
    dot_eaten     = int'($urandom_range(99, 0)) < p_dot;
    big_dot_eaten = int'($urandom_range(99, 0)) < p_big;
    model_step(reset, tick, start, dot_eaten, big_dot_eaten, e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Stimulus process
  initial begin : driver
    bit found;
    repeat (3) drive_cycle(1'b1);
    for (int seg = 0; seg < 40; seg++) begin
      case (seg % 4)
        0: p_near = 0;
        1: p_near = 3;
        2: p_near = 15;
        default: p_near = 50;
      endcase
      p_rst = (seg % 5 == 4) ? 2 : 0;
      for (int c = 0; c < 400; c++) drive_cycle(1'b0);
    end
    // Drive into DYING, then reset in the middle of the countdown
    p_rst  = 0;
    p_near = 60;
    found  = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      drive_cycle(1'b0);
      if (m_state == 3 && m_phase == 4) found = 1'b1;
    end
    if (!found) begin
      n_fail++;
      $display("FAIL dying_reach: got no DYING phase 4, expected one within 5000 cycles");
    end
    drive_cycle(1'b1);
    p_start = 0;
    repeat (3) drive_cycle(1'b0);
    done = 1'b1;
  end

  // Monitor: pops one expectation per clock and compares every output
  initial begin : monitor
    exp_t e;
    int   prev_st;
    int   cyc;
    prev_st = -1;
    cyc     = 0;
    while (!(done && exp_q.size() == 0)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 60000) begin
        n_fail++;
        $display("FAIL timeout: got %0d cycles, expected under 60000", cyc);
        break;
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("game_state",  32'(game_state),  32'(e.st));
        check("score",       32'(score),       32'(e.sc));
        check("lives",       32'(lives),       32'(e.lv));
        check("move_enable", 32'(move_enable), 32'(e.me));
        check("power_mode",  32'(power_mode),  32'(e.pm));
        check("ghost_home",  32'(ghost_home),  32'(e.gh));
        check("round_reset", 32'(round_reset), 32'(e.rr));
        check("maze_reload", 32'(maze_reload), 32'(e.mr));
        if (e.st != prev_st || e.gh != 0)
          $display("txn t=%0t state=%0d score=%0d lives=%0d ghost_home=%b",
                   $time, game_state, score, lives, ghost_home);
        prev_st = e.st;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Central game sequencer for the PAC-MAN top level. It owns game_state, score, lives, the dot counter and the power-pellet timer. It detects player/ghost collisions on each character-update tick and issues move-enable and reset pulses to PlayerControl, the GhostNControl blocks and the tilemap.
It sits between the character controllers and Renderer, replacing the constant game_state tie-off.

Parameters:
TOTAL_DOTS, 240, dots + big dots on a fresh maze; loaded into dots_left.
START_LIVES, 3, lives after reset or restart (1..3).
READY_TICKS, 10, ticks spent in READY before PLAYING.
DYING_TICKS, 8, ticks spent in DYING.
POWER_TICKS, 40, power-mode duration in ticks.
HIT_DIST, 12, collision threshold in pixels per axis (strict less-than).

Ports:
clk  in  1  system clock (clk_50MHz domain)
reset  in  1  synchronous, active-high
tick  in  1  one-cycle strobe, one per character update (derived from clk_100Hz edge)
start  in  1  level; sampled only in IDLE/GAME_OVER/WIN
dot_eaten  in  1  one-cycle pulse from player control
big_dot_eaten  in  1  one-cycle pulse from player control
player_x  in  10  player pixel x
player_y  in  9  player pixel y
ghost_x  in  40  {g4,g3,g2,g1} x, 10 bits each
ghost_y  in  36  {g4,g3,g2,g1} y, 9 bits each
game_state  out  3  IDLE=0 READY=1 PLAYING=2 DYING=3 GAME_OVER=4 WIN=5
move_enable  out  1  1 only in PLAYING
power_mode  out  1  power_cnt != 0
score  out  16  binary, saturating
lives  out  2  remaining lives
ghost_home  out  4  one-cycle pulse per ghost: return to pen
round_reset  out  1  one-cycle pulse: player and ghosts to start positions
maze_reload  out  1  one-cycle pulse: restore dot/big-dot tilemaps

Behaviour:
- Reset (sync, active-high, overrides everything): game_state=IDLE, score=0, lives=START_LIVES, dots_left=TOTAL_DOTS, power_cnt=0, combo=0, phase counter=0. All pulse outputs are 0 and move_enable=0. Reset mid-game aborts immediately, with no pulses emitted.
- Registered outputs: all outputs change on the clk edge following the causing event, with 1-cycle latency.
- IDLE: start=1 -> READY; maze_reload and round_reset pulse in that same transition cycle.
- READY: the phase counter counts ticks. After READY_TICKS ticks -> PLAYING, with the counter cleared.
- PLAYING, any cycle (not tick-gated):
  - dot_eaten adds 10 to score; big_dot_eaten adds 50. If both arrive, add 60 and decrement dots_left by 2.
  - big_dot_eaten loads power_cnt=POWER_TICKS (retriggers if already nonzero) and clears combo.
  - dots_left never underflows below 0.
- PLAYING, on tick: evaluate ghosts 1..4 in parallel. Ghost k hits when |px-gx_k|<HIT_DIST and |py-gy_k|<HIT_DIST, using unsigned abs-diff computed at 10 bits.
  - power_mode=1, hit on ghost k: pulse ghost_home[k]. Each eaten ghost in index order adds 200<<combo, with combo capped at 3 (200/400/800/1600), then combo increments (saturates at 3).
  - power_mode=0 and any hit: -> DYING. Power_cnt is cleared, the phase counter cleared, and dot pulses in that cycle are ignored.
  - No fatal hit and dots_left reaches 0 (including from a dot pulse in the same cycle): -> WIN.
  - A fatal hit wins over the last dot in the same cycle.
  - power_cnt decrements by 1 per tick while nonzero; reaching 0 clears combo.
- DYING: after DYING_TICKS ticks, lives is decremented.
  - If lives was 1: lives=0 -> GAME_OVER.
  - Otherwise -> READY with a round_reset pulse; dots_left and score are retained.
- GAME_OVER / WIN: hold all values. start=1 -> READY with score=0, lives=START_LIVES, dots_left=TOTAL_DOTS, power_cnt=0, and maze_reload plus round_reset pulsed.
- Dot pulses and tick outside PLAYING never change score, dots_left or power_cnt, except that ticks advance the READY/DYING counters.
- Score arithmetic: 17-bit sum, clamped to 16'hFFFF on overflow.
- Timing: tick and dot pulses are single clk cycles; back-to-back ticks are legal and each one counts.

Test Plan:
- Reset, start=1, 10 ticks -> game_state 0->1->2, maze_reload and round_reset each high for exactly 1 cycle, move_enable=1 only after the 10th tick.
- PLAYING, 3 dot_eaten plus 1 simultaneous dot_eaten&big_dot_eaten -> score=90, dots_left=TOTAL_DOTS-5, power_mode=1; 40 ticks later power_mode=0.
- Power mode, ghosts 2 and 3 at player position on the same tick -> ghost_home=4'b0110 for 1 cycle, score +600 (200+400); next tick ghost 1 hit -> +800.
- No power, ghost 4 within 11 px on both axes -> DYING; 8 ticks -> lives 3->2, READY with round_reset; repeat twice more -> GAME_OVER, lives=0, start -> score=0, lives=3.
- TOTAL_DOTS=2: two dot pulses -> WIN; a last dot and fatal hit on the same tick -> DYING, not WIN; ghost at exactly HIT_DIST distance -> no hit.
- Assert reset in DYING mid-count -> next cycle IDLE, all outputs at reset values, no pulses.
